// File: rtl/round_step_sequencer.sv
// ----------------------------------------------------------------------------
// round_step_sequencer
//
// Top-level scheduler for the permutation datapath. Launches each step
// controller in fixed order with a one-cycle start pulse, then waits for that
// step's done level. It repeats this for ROUNDS rounds and toggles the
// ping-pong slice-memory bank select after every step. A per-step watchdog
// moves the sequencer to an error state when a step hangs. The abort input
// cancels a run from any active state.
//
// Ports
//   clk         in   1          clock, rising edge
//   rst         in   1          asynchronous, active-high reset
//   start       in   1          run request, sampled in IDLE only
//   abort       in   1          cancel the run (any state except IDLE)
//   step_done   in   NUM_STEPS  per-step completion level; only [step_idx] is used
//   step_start  out  NUM_STEPS  one-hot launch pulse to step controller [step_idx]
//   step_idx    out  STEP_W     current step
//   round_idx   out  ROUND_W    current round
//   bank_sel    out  1          steps read bank bank_sel and write ~bank_sel
//   busy        out  1          high in LAUNCH, WAIT, SWAP, FINISH
//   done        out  1          one-cycle pulse when all rounds are complete
//   err         out  1          held high while in ERROR
//   err_step    out  STEP_W     step_idx captured on watchdog timeout
// ----------------------------------------------------------------------------
module round_step_sequencer #(
   parameter int NUM_STEPS = 5,
   parameter int STEP_W    = 3,
   parameter int ROUNDS    = 24,
   parameter int ROUND_W   = 5,
   parameter int TIMEOUT   = 255,
   parameter int WD_W      = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   input  logic [NUM_STEPS-1:0] step_done,
   output logic [NUM_STEPS-1:0] step_start,
   output logic [STEP_W-1:0]    step_idx,
   output logic [ROUND_W-1:0]   round_idx,
   output logic                 bank_sel,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [STEP_W-1:0]    err_step
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT,
      S_SWAP,
      S_FINISH,
      S_ERROR
   } state_t;

   localparam logic [STEP_W-1:0]  L_STEP_LAST  = STEP_W'(NUM_STEPS - 1);
   localparam logic [ROUND_W-1:0] L_ROUND_LAST = ROUND_W'(ROUNDS - 1);
   localparam bit                 L_WD_EN      = (TIMEOUT != 0);
   localparam logic [WD_W-1:0]    L_WD_LAST    = WD_W'(L_WD_EN ? TIMEOUT - 1 : 0);

   state_t              r_state,     w_state_nxt;
   logic [STEP_W-1:0]   r_step_idx,  w_step_idx_nxt;
   logic [ROUND_W-1:0]  r_round_idx, w_round_idx_nxt;
   logic                r_bank_sel,  w_bank_sel_nxt;
   logic [WD_W-1:0]     r_wd,        w_wd_nxt;
   logic [STEP_W-1:0]   r_err_step,  w_err_step_nxt;

   logic                w_cur_done;
   logic                w_launch;

   // Select the done level of the current step only; every other bit is a
   // don't-care so stray completions from idle controllers cannot advance us.
   always_comb begin
      w_cur_done = 1'b0;
      for (int i = 0; i < NUM_STEPS; i++) begin
         if (r_step_idx == STEP_W'(i)) begin
            w_cur_done = step_done[i];
         end
      end
   end

   // Launch pulse is decoded from the state so it lasts exactly the one LAUNCH
   // cycle and drops to zero as soon as reset or abort leaves that state.
   assign w_launch = (r_state == S_LAUNCH);

   always_comb begin
      step_start = '0;
      for (int i = 0; i < NUM_STEPS; i++) begin
         step_start[i] = w_launch && (r_step_idx == STEP_W'(i));
      end
   end

   // Next-state and next-register logic.
   always_comb begin
      // NOTE: every signal gets a default before the case, so no path can leave
      // one unassigned and infer a latch.
      w_state_nxt     = r_state;
      w_step_idx_nxt  = r_step_idx;
      w_round_idx_nxt = r_round_idx;
      w_bank_sel_nxt  = r_bank_sel;
      w_wd_nxt        = r_wd;
      w_err_step_nxt  = r_err_step;

      // Abort outranks everything except reset; bank_sel deliberately holds so
      // the datapath knows which bank carries the last completed write.
      if (abort && (r_state != S_IDLE)) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  w_state_nxt     = S_LAUNCH;
                  w_step_idx_nxt  = '0;
                  w_round_idx_nxt = '0;
                  w_bank_sel_nxt  = 1'b0;
                  w_wd_nxt        = '0;
               end
            end

            S_LAUNCH: begin
               w_wd_nxt    = '0;
               w_state_nxt = S_WAIT;
            end

            S_WAIT: begin
               // Completion is checked before the watchdog so a step finishing
               // on the last allowed cycle still counts as success.
               if (w_cur_done) begin
                  w_state_nxt = S_SWAP;
               end else if (L_WD_EN && (r_wd == L_WD_LAST)) begin
                  w_state_nxt    = S_ERROR;
                  w_err_step_nxt = r_step_idx;
               end else if (L_WD_EN) begin
                  w_wd_nxt = r_wd + 1'b1;
               end
            end

            S_SWAP: begin
               w_bank_sel_nxt = ~r_bank_sel;
               if (r_step_idx != L_STEP_LAST) begin
                  w_step_idx_nxt = r_step_idx + 1'b1;
                  w_state_nxt    = S_LAUNCH;
               end else begin
                  w_step_idx_nxt = '0;
                  if (r_round_idx != L_ROUND_LAST) begin
                     w_round_idx_nxt = r_round_idx + 1'b1;
                     w_state_nxt     = S_LAUNCH;
                  end else begin
                     w_state_nxt = S_FINISH;
                  end
               end
            end

            S_FINISH: begin
               w_state_nxt = S_IDLE;
            end

            // Only abort (handled above) or reset leaves ERROR.
            S_ERROR: begin
               w_state_nxt = S_ERROR;
            end

            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_step_idx  <= '0;
         r_round_idx <= '0;
         r_bank_sel  <= 1'b0;
         r_wd        <= '0;
         r_err_step  <= '0;
      end else begin
         // NOTE: non-blocking assignments here, so all registers update together
         // from the values computed in the previous cycle.
         r_state     <= w_state_nxt;
         r_step_idx  <= w_step_idx_nxt;
         r_round_idx <= w_round_idx_nxt;
         r_bank_sel  <= w_bank_sel_nxt;
         r_wd        <= w_wd_nxt;
         r_err_step  <= w_err_step_nxt;
      end
   end

   assign step_idx  = r_step_idx;
   assign round_idx = r_round_idx;
   assign bank_sel  = r_bank_sel;
   assign err_step  = r_err_step;
   assign busy      = (r_state == S_LAUNCH) || (r_state == S_WAIT) ||
                      (r_state == S_SWAP)   || (r_state == S_FINISH);
   assign done      = (r_state == S_FINISH);
   assign err       = (r_state == S_ERROR);

endmodule

// File: tb/tb_round_step_sequencer.sv
// ----------------------------------------------------------------------------
// tb_round_step_sequencer
//
// Directed bench for round_step_sequencer. The main instance uses
// NUM_STEPS=5, ROUNDS=2 and TIMEOUT=8. A second instance uses TIMEOUT=0 and
// has its own start/abort/step_done inputs, so a long step can run without
// the watchdog. A small responder echoes step_start back as step_done one
// cycle later. A mask can hold back a chosen step, and a stray mode drives
// every non-current done bit.
// ----------------------------------------------------------------------------
module tb_round_step_sequencer;

   localparam int NS = 5;
   localparam int SW = 3;
   localparam int RW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          start, abort;
   logic [NS-1:0] step_done, step_start;
   logic [SW-1:0] step_idx, err_step;
   logic [RW-1:0] round_idx;
   logic          bank_sel, busy, done, err;

   logic          start0, abort0;
   logic [NS-1:0] step_done0, step_start0;
   logic [SW-1:0] step_idx0, err_step0;
   logic [RW-1:0] round_idx0;
   logic          bank_sel0, busy0, done0, err0;

   // Responder state
   logic [NS-1:0] seen = '0;
   logic [NS-1:0] resp = '0;
   logic [NS-1:0] block_mask, manual_done, w_cur;
   bit            echo_en, stray_en;

   int n_checks = 0;
   int n_fail   = 0;
   int pulses, toggles, done_cyc, busy_cyc, n_done;

   round_step_sequencer #(
      .NUM_STEPS(NS), .STEP_W(SW), .ROUNDS(2), .ROUND_W(RW), .TIMEOUT(8), .WD_W(8)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .step_done(step_done),
      .step_start(step_start), .step_idx(step_idx), .round_idx(round_idx),
      .bank_sel(bank_sel), .busy(busy), .done(done), .err(err), .err_step(err_step)
   );

   round_step_sequencer #(
      .NUM_STEPS(NS), .STEP_W(SW), .ROUNDS(2), .ROUND_W(RW), .TIMEOUT(0), .WD_W(8)
   ) dut0 (
      .clk(clk), .rst(rst), .start(start0), .abort(abort0), .step_done(step_done0),
      .step_start(step_start0), .step_idx(step_idx0), .round_idx(round_idx0),
      .bank_sel(bank_sel0), .busy(busy0), .done(done0), .err(err0), .err_step(err_step0)
   );

   always #5 clk = ~clk;

   // Echo: whatever launched in the previous cycle reports done one cycle later.
   always @(negedge clk) seen = step_start;
   always @(posedge clk) begin
      #1;
      resp = echo_en ? (seen & ~block_mask) : '0;
   end

   assign w_cur     = 5'b00001 << step_idx;
   assign step_done = resp | manual_done | (stray_en ? ~w_cur : 5'b00000);

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Watches ncyc cycles starting at the first LAUNCH and checks launch order.
   task automatic observe(input int ncyc);
      logic prev_bank;
      int   exp_s, exp_r;
      prev_bank = bank_sel;
      exp_s = 0; exp_r = 0;
      pulses = 0; toggles = 0; done_cyc = 0; busy_cyc = 0; n_done = 0;
      for (int c = 1; c <= ncyc; c++) begin
         if (step_start != '0) begin
            check("order_onehot", 32'(step_start), 32'(1) << exp_s);
            check("order_round", 32'(round_idx), 32'(exp_r));
            pulses++;
            exp_s++;
            if (exp_s == NS) begin
               exp_s = 0;
               exp_r++;
            end
         end
         if (bank_sel != prev_bank) toggles++;
         prev_bank = bank_sel;
         if (done) begin
            n_done++;
            if (done_cyc == 0) done_cyc = c;
         end
         if (busy) busy_cyc++;
         @(negedge clk);
      end
   endtask

   task automatic wait_for_pulse(input logic [NS-1:0] want, input int rnd);
      int n = 0;
      while (!((step_start == want) && (round_idx == RW'(rnd))) && (n < 80)) begin
         @(negedge clk);
         n++;
      end
      check("wait_pulse_found", 32'(n < 80), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench stopped by global time limit");
   end

   initial begin
      int c;
      rst = 1'b1; start = 1'b0; abort = 1'b0;
      start0 = 1'b0; abort0 = 1'b0; step_done0 = '0;
      block_mask = '0; manual_done = '0; echo_en = 1'b0; stray_en = 1'b0;
      repeat (2) @(negedge clk);

      // Reset state
      check("rst_step_start", 32'(step_start), 0);
      check("rst_idx", 32'({round_idx, step_idx}), 0);
      check("rst_flags", 32'({bank_sel, busy, done, err}), 0);
      check("rst_err_step", 32'(err_step), 0);
      rst = 1'b0;
      @(negedge clk);

      // 1: full run with echoed completion
      echo_en = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      observe(31);
      check("t1_pulses", 32'(pulses), 10);
      check("t1_toggles", 32'(toggles), 10);
      check("t1_done_cycle", 32'(done_cyc), 31);
      check("t1_done_count", 32'(n_done), 1);
      check("t1_busy_cycles", 32'(busy_cyc), 31);
      check("t1_busy_after", 32'(busy), 0);
      check("t1_done_after", 32'(done), 0);
      check("t1_bank_end", 32'(bank_sel), 0);
      check("t1_round_end", 32'(round_idx), 1);
      check("t1_step_end", 32'(step_idx), 0);

      // 2: step 2 of round 0 hangs -> watchdog
      block_mask = 5'b00100;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      c = 1;
      while (!err && (c < 60)) begin
         @(negedge clk);
         c++;
      end
      check("t2_err_cycle", 32'(c), 16);
      check("t2_err", 32'(err), 1);
      check("t2_err_step", 32'(err_step), 2);
      check("t2_busy", 32'(busy), 0);
      check("t2_step_idx", 32'(step_idx), 2);
      start = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t2_start_ignored_launch", 32'(step_start), 0);
         check("t2_start_ignored_err", 32'(err), 1);
      end
      start = 1'b0;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      block_mask = '0;
      check("t2_abort_err", 32'(err), 0);
      check("t2_abort_busy", 32'(busy), 0);

      // 3: abort in WAIT of round 1 step 3
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_for_pulse(5'b01000, 1);
      @(negedge clk);
      check("t3_in_wait_busy", 32'(busy), 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("t3_abort_busy", 32'(busy), 0);
      check("t3_abort_bank", 32'(bank_sel), 0);
      pulses = 0; n_done = 0;
      for (int i = 0; i < 5; i++) begin
         if (step_start != '0) pulses++;
         if (done) n_done++;
         @(negedge clk);
      end
      check("t3_no_pulse", 32'(pulses), 0);
      check("t3_no_done", 32'(n_done), 0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("t3_restart_pulse", 32'(step_start), 32'b00001);
      check("t3_restart_idx", 32'({round_idx, step_idx}), 0);
      check("t3_restart_bank", 32'(bank_sel), 0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;

      // 4: done on the last watchdog cycle; done held through LAUNCH
      echo_en = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      check("t4_wait8_busy", 32'(busy), 1);
      check("t4_wait8_err", 32'(err), 0);
      manual_done = 5'b00001;
      @(negedge clk);
      check("t4_edge_no_err", 32'(err), 0);
      check("t4_edge_busy", 32'(busy), 1);
      manual_done = 5'b00010;
      @(negedge clk);
      check("t4_launch1", 32'(step_start), 32'b00010);
      check("t4_bank1", 32'(bank_sel), 1);
      @(negedge clk);
      check("t4_wait_no_pulse", 32'(step_start), 0);
      @(negedge clk);
      check("t4_swap_no_pulse", 32'(step_start), 0);
      check("t4_swap_idx", 32'(step_idx), 1);
      manual_done = '0;
      @(negedge clk);
      check("t4_launch2", 32'(step_start), 32'b00100);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;

      // 5: stray done bits, start held -> relaunch after done
      echo_en = 1'b1;
      stray_en = 1'b1;
      start = 1'b1;
      @(negedge clk);
      observe(31);
      check("t5_pulses", 32'(pulses), 10);
      check("t5_toggles", 32'(toggles), 10);
      check("t5_done_cycle", 32'(done_cyc), 31);
      check("t5_idle_busy", 32'(busy), 0);
      @(negedge clk);
      check("t5_relaunch", 32'(step_start), 32'b00001);
      check("t5_relaunch_busy", 32'(busy), 1);
      start = 1'b0;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      stray_en = 1'b0;

      // 6a: asynchronous reset mid-WAIT (round 1 step 2, bank_sel=1)
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_for_pulse(5'b00100, 1);
      @(negedge clk);
      check("t6_pre_bank", 32'(bank_sel), 1);
      #2 rst = 1'b1;
      #1;
      check("t6_rst_pulse", 32'(step_start), 0);
      check("t6_rst_idx", 32'({round_idx, step_idx}), 0);
      check("t6_rst_flags", 32'({bank_sel, busy, done, err}), 0);
      check("t6_rst_err_step", 32'(err_step), 0);
      @(negedge clk);
      rst = 1'b0;
      echo_en = 1'b0;
      @(negedge clk);
      check("t6_idle_busy", 32'(busy), 0);

      // 6b: watchdog disabled, 1000-cycle step
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      repeat (1000) @(negedge clk);
      check("t6_long_err", 32'(err0), 0);
      check("t6_long_busy", 32'(busy0), 1);
      check("t6_long_idx", 32'(step_idx0), 0);
      step_done0 = 5'b00001;
      @(negedge clk);
      step_done0 = '0;
      @(negedge clk);
      check("t6_long_next", 32'(step_start0), 32'b00010);
      check("t6_long_bank", 32'(bank_sel0), 1);
      abort0 = 1'b1;
      @(negedge clk);
      abort0 = 1'b0;
      check("t6_abort_busy", 32'(busy0), 0);
      check("t6_abort_bank_hold", 32'(bank_sel0), 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
